// File: rtl/line_buf_sched.sv
// Ring scheduler for BUF_CNT line buffers: steers input lines into a write buffer,
// pops the oldest unread buffer on downstream request and counts dropped lines.
module line_buf_sched #(
  parameter int BUF_CNT    = 2,
  parameter int PX_PER_CLK = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [PX_PER_CLK-1:0]           px_data_val_i,
  input  logic                            line_end_i,
  input  logic                            line_req_i,
  input  logic [BUF_CNT-1:0]              buf_empty_i,
  input  logic [BUF_CNT-1:0]              buf_unread_i,
  input  logic [BUF_CNT-1:0]              buf_line_end_i,
  output logic [BUF_CNT*PX_PER_CLK-1:0]   buf_px_val_o,
  output logic [BUF_CNT-1:0]              buf_pop_o,
  output logic [$clog2(BUF_CNT)-1:0]      rd_sel_o,
  output logic                            rd_busy_o,
  output logic                            line_avail_o,
  output logic [CNT_WIDTH-1:0]            drop_cnt_o
);

  localparam int IDX_W = $clog2(BUF_CNT);

  typedef enum logic [1:0] {
    IDLE,
    POP,
    READ
  } state_t;

  state_t                 state_q;
  logic [BUF_CNT-1:0]     bufPop_q;
  logic [IDX_W-1:0]       wrIdx_q, wrIdx_d;
  logic [IDX_W-1:0]       rdIdx_q, rdIdx_d;
  logic [CNT_WIDTH-1:0]   dropCnt_q, dropCnt_d;

  logic                   wrEnd;
  logic [IDX_W-1:0]       nextWr;
  logic                   collide;
  logic                   dropOldest;
  logic                   dropInFlight;
  logic                   lineAvail;
  logic                   readDone;

  function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] x);
    return (x == IDX_W'(BUF_CNT - 1)) ? '0 : x + IDX_W'(1);
  endfunction

  // Write-side decisions always look at the pre-update read state and index.
  always_comb begin
    wrEnd        = (|px_data_val_i) && line_end_i;
    nextWr       = nextIdx(wrIdx_q);
    collide      = wrEnd && (nextWr == rdIdx_q);
    dropOldest   = collide && (state_q == IDLE) && buf_unread_i[nextWr];
    dropInFlight = collide && (state_q != IDLE);
    lineAvail    = (state_q == IDLE) && buf_unread_i[rdIdx_q] && !buf_empty_i[rdIdx_q];
    readDone     = (state_q == READ) && buf_line_end_i[rdIdx_q];
  end

  always_comb begin
    wrIdx_d   = wrIdx_q;
    rdIdx_d   = rdIdx_q;
    dropCnt_d = dropCnt_q;
    if (wrEnd && !dropInFlight) begin
      wrIdx_d = nextWr;
    end
    if (dropOldest) begin
      rdIdx_d = nextIdx(nextWr);
    end else if (readDone) begin
      rdIdx_d = nextIdx(rdIdx_q);
    end
    if ((dropOldest || dropInFlight) && (dropCnt_q != '1)) begin
      dropCnt_d = dropCnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrIdx_q   <= '0;
      rdIdx_q   <= '0;
      dropCnt_q <= '0;
    end else begin
      wrIdx_q   <= wrIdx_d;
      rdIdx_q   <= rdIdx_d;
      dropCnt_q <= dropCnt_d;
    end
  end

  // A drop-oldest moves rdIdx this cycle, so a pop of the stale index is held off.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      bufPop_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          bufPop_q <= '0;
          if (line_req_i && lineAvail && !dropOldest) begin
            state_q  <= POP;
            bufPop_q <= BUF_CNT'(1) << rdIdx_q;
          end
        end
        POP: begin
          bufPop_q <= '0;
          state_q  <= READ;
        end
        READ: begin
          bufPop_q <= '0;
          if (buf_line_end_i[rdIdx_q]) begin
            state_q <= IDLE;
          end
        end
        default: begin
          bufPop_q <= '0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    buf_px_val_o = '0;
    for (int k = 0; k < BUF_CNT; k++) begin
      if (wrIdx_q == IDX_W'(k)) begin
        buf_px_val_o[k*PX_PER_CLK +: PX_PER_CLK] = px_data_val_i;
      end
    end
  end

  assign buf_pop_o    = bufPop_q;
  assign rd_sel_o     = rdIdx_q;
  assign rd_busy_o    = (state_q != IDLE);
  assign line_avail_o = lineAvail;
  assign drop_cnt_o   = dropCnt_q;

endmodule
